// File: rtl/camera_pkg.sv
// ============================================================================
// camera_pkg : shared frame geometry, coordinate width and FSM encoding. Rev 1.0
// ============================================================================
`default_nettype none

package camera_pkg;

  localparam int H_ACTIVE_DEFAULT = 320;
  localparam int V_ACTIVE_DEFAULT = 240;
  localparam int COORD_W          = 10;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_ARMED   = ARMED,
    ST_CAPTURE = CAPTURE
  } state_t;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/camera_frame_writer_if.sv
// ============================================================================
// camera_frame_writer_if : camera stream in, video-memory write port out. Rev 1.0
// ============================================================================
`default_nettype none

interface camera_frame_writer_if;
  import camera_pkg::*;

  logic                camera_request;
  logic                cam_vsync;
  logic                cam_href;
  logic [7:0]          cam_data;
  logic [COORD_W-1:0]  camera_hcount;
  logic [COORD_W-1:0]  camera_vcount;
  logic [15:0]         dout_camera;
  logic                mwe_camera;
  logic                busy;
  logic                frame_done;
  logic                overflow;

  modport master (
    output camera_request, cam_vsync, cam_href, cam_data,
    input  camera_hcount, camera_vcount, dout_camera, mwe_camera,
           busy, frame_done, overflow
  );

  modport slave (
    input  camera_request, cam_vsync, cam_href, cam_data,
    output camera_hcount, camera_vcount, dout_camera, mwe_camera,
           busy, frame_done, overflow
  );

endinterface

`default_nettype wire

// File: rtl/camera_byte_assembler.sv
// ============================================================================
// camera_byte_assembler : input registers, byte pairing, line/frame edges. Rev 1.0
// ============================================================================
`default_nettype none

module camera_byte_assembler #(
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  wire logic        clk_camera,
  input  wire logic        reset_n,
  input  wire logic        capture,
  input  wire logic        cam_vsync,
  input  wire logic        cam_href,
  input  wire logic [7:0]  cam_data,
  output logic             pix_valid,
  output logic [15:0]      pix_data,
  output logic             line_end,
  output logic             frame_start,
  output logic             frame_end
);

  logic       vsync_q;
  logic       href_q;
  logic [7:0] data_q;
  logic       href_d;
  logic       vs_active_d;
  logic       phase;
  logic [7:0] hi_byte;
  logic       vs_active;

  assign vs_active = ~(vsync_q ^ VSYNC_ACTIVE_HIGH);

  always_ff @(posedge clk_camera) begin
    if (!reset_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= '0;
      href_d      <= 1'b0;
      vs_active_d <= 1'b0;
      phase       <= 1'b0;
      hi_byte     <= '0;
    end else begin
      vsync_q     <= cam_vsync;
      href_q      <= cam_href;
      data_q      <= cam_data;
      href_d      <= href_q;
      vs_active_d <= vs_active;
      // Phase restarts every line so an odd trailing byte never pairs across lines.
      if (!capture || line_end) begin
        phase <= 1'b0;
      end else if (href_q && !vs_active) begin
        phase <= ~phase;
        if (!phase) begin
          hi_byte <= data_q;
        end
      end
    end
  end

  assign pix_valid   = capture && href_q && !vs_active && phase;
  assign pix_data    = {hi_byte, data_q};
  assign line_end    = href_d && !href_q;
  assign frame_start = vs_active_d && !vs_active;
  assign frame_end   = !vs_active_d && vs_active;

endmodule

`default_nettype wire

// File: rtl/camera_frame_writer.sv
// ============================================================================
// camera_frame_writer : capture FSM, coordinate counters and write port. Rev 1.0
// ============================================================================
`default_nettype none

module camera_frame_writer
  import camera_pkg::*;
#(
  parameter int H_ACTIVE          = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE          = V_ACTIVE_DEFAULT,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input wire logic               clk_camera,
  input wire logic               reset_n,
  camera_frame_writer_if.slave   cam
);

  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

  state_t             state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               pix_valid;
  logic [15:0]        pix_data;
  logic               line_end;
  logic               frame_start;
  logic               frame_end;

  camera_byte_assembler #(
    .VSYNC_ACTIVE_HIGH (VSYNC_ACTIVE_HIGH)
  ) u_asm (
    .clk_camera  (clk_camera),
    .reset_n     (reset_n),
    .capture     (state == ST_CAPTURE),
    .cam_vsync   (cam.cam_vsync),
    .cam_href    (cam.cam_href),
    .cam_data    (cam.cam_data),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .line_end    (line_end),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always_ff @(posedge clk_camera) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      x                 <= '0;
      y                 <= '0;
      cam.camera_hcount <= '0;
      cam.camera_vcount <= '0;
      cam.dout_camera   <= '0;
      cam.mwe_camera    <= 1'b0;
      cam.busy          <= 1'b0;
      cam.frame_done    <= 1'b0;
      cam.overflow      <= 1'b0;
    end else begin
      cam.mwe_camera <= 1'b0;
      cam.frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cam.camera_request) begin
            state        <= ST_ARMED;
            cam.busy     <= 1'b1;
            cam.overflow <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (frame_start) begin
            state <= ST_CAPTURE;
            x     <= '0;
            y     <= '0;
          end
        end
        ST_CAPTURE: begin
          // The sync edge that closes a frame also re-arms, so held requests skip nothing.
          if (frame_end) begin
            cam.frame_done <= 1'b1;
            if (cam.camera_request) begin
              state <= ST_ARMED;
            end else begin
              state    <= ST_IDLE;
              cam.busy <= 1'b0;
            end
          end else if (pix_valid) begin
            if (x < H_LIM && y < V_LIM) begin
              cam.camera_hcount <= x;
              cam.camera_vcount <= y;
              cam.dout_camera   <= pix_data;
              cam.mwe_camera    <= 1'b1;
            end else begin
              cam.overflow <= 1'b1;
            end
            x <= sat_inc(x);
          end else if (line_end && x != '0) begin
            y <= sat_inc(y);
            x <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cam.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
